psk_acq_dispatcher: RTL and testbench

- Parametrised successor of the single-phase PSK correlator dispatcher: searches N_HYP carrier-phase hypotheses instead of evaluating one fixed phase.
- For each hypothesis it runs I/Q 1-bit NCO codes against the 1-bit input, integrates over a dwell, and computes non-coherent power I²+Q².
- Reports every hypothesis power plus the index and power of the best one.
- Sits between the 1-bit sampler and the acquisition/tracking controller, which starts it and reads the result.

---
 rtl/psk_acq_pkg.sv | 15 +
 rtl/psk_iq_integrator.sv | 63 ++++++
 rtl/psk_acq_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_psk_acq_dispatcher.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_acq_pkg.sv
// Shared types and helpers for the PSK phase-hypothesis acquisition search.
package psk_acq_pkg;

  typedef enum logic [1:0] {IDLE, DWELL, EVAL, DONE} state_t;

  function automatic int unsigned quarter_phase(input int unsigned phase_w);
    return 32'd1 << (phase_w - 32'd2);
  endfunction

  // Non-coherent power of one I/Q pair; caller truncates to its power width.
  function automatic longint unsigned pow_of(input longint signed i, input longint signed q);
    return $unsigned(i * i + q * q);
  endfunction

endpackage

// File: rtl/psk_iq_integrator.sv
// 1-bit I/Q NCO correlator: phase accumulator, quadrature code pair and two signed +/-1 integrators.
// One sample per cycle when en_i is high; clear_i/load_phase_i take priority over the update.
module psk_iq_integrator #(
  parameter int PHASE_W = 12,
  parameter int ACC_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clear_i,
  input  logic                     load_phase_i,
  input  logic                     en_i,
  input  logic                     sig_i,
  input  logic [PHASE_W-1:0]       phase_ld_i,
  input  logic [PHASE_W-1:0]       fcw_i,
  output logic signed [ACC_W-1:0] i_acc_o,
  output logic signed [ACC_W-1:0] q_acc_o
);
  import psk_acq_pkg::*;

  localparam logic [PHASE_W-1:0] QOFF = PHASE_W'(quarter_phase(PHASE_W));
  localparam logic signed [ACC_W-1:0] STEP_P = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] STEP_N = '1;

  logic [PHASE_W-1:0] phase_q, phase_d, phase_qoff;
  logic signed [ACC_W-1:0] i_acc_q, i_acc_d, q_acc_q, q_acc_d;
  logic code_i, code_q;

  assign phase_qoff = phase_q + QOFF;
  assign code_i     = phase_q[PHASE_W-1];
  assign code_q     = phase_qoff[PHASE_W-1];

  always_comb begin
    phase_d = phase_q;
    i_acc_d = i_acc_q;
    q_acc_d = q_acc_q;
    if (en_i) begin
      phase_d = phase_q + fcw_i;
      i_acc_d = i_acc_q + ((sig_i == code_i) ? STEP_P : STEP_N);
      q_acc_d = q_acc_q + ((sig_i == code_q) ? STEP_P : STEP_N);
    end
    if (clear_i) begin
      i_acc_d = '0;
      q_acc_d = '0;
    end
    if (load_phase_i) phase_d = phase_ld_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      phase_q <= '0;
      i_acc_q <= '0;
      q_acc_q <= '0;
    end else begin
      phase_q <= phase_d;
      i_acc_q <= i_acc_d;
      q_acc_q <= q_acc_d;
    end
  end

  assign i_acc_o = i_acc_q;
  assign q_acc_o = q_acc_q;

endmodule

// File: rtl/psk_acq_dispatcher.sv
// Searches N_HYP carrier-phase hypotheses, reporting each power and the best; no backpressure.
// Latency start->done is N_HYP*(DWELL_LEN+1)+1 cycles with sample_en_i held high.
module psk_acq_dispatcher #(
  parameter int PHASE_W   = 12,
  parameter int ACC_W     = 8,
  parameter int DWELL_LEN = 96,
  parameter int N_HYP     = 16,
  parameter int IDX_W     = $clog2(N_HYP),
  parameter int POW_W     = 2 * ACC_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               sig_i,
  input  logic               sample_en_i,
  input  logic               start_i,
  input  logic [PHASE_W-1:0] fcw_i,
  input  logic [PHASE_W-1:0] pcw_step_i,
  output logic               busy_o,
  output logic               hyp_stb_o,
  output logic [IDX_W-1:0]   hyp_idx_o,
  output logic [POW_W-1:0]   hyp_pow_o,
  output logic               done_o,
  output logic [IDX_W-1:0]   best_idx_o,
  output logic [POW_W-1:0]   best_pow_o
);
  import psk_acq_pkg::*;

  localparam int CNT_W = $clog2(DWELL_LEN + 1);

  generate
    if (DWELL_LEN > (2 ** (ACC_W - 1)) - 1) begin : g_bad_acc_w
      $error("DWELL_LEN does not fit the signed integrator width");
    end
    if (DWELL_LEN < 1 || N_HYP < 2) begin : g_bad_dims
      $error("DWELL_LEN must be >= 1 and N_HYP >= 2");
    end
  endgenerate

  state_t state_q, state_d;
  logic [PHASE_W-1:0] fcw_q, fcw_d, pcw_q, pcw_d, off_q, off_d;
  logic [IDX_W-1:0]   hyp_q, hyp_d, hyp_idx_q, hyp_idx_d, best_idx_q, best_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hyp_stb_q, hyp_stb_d;
  logic [POW_W-1:0]   hyp_pow_q, hyp_pow_d, best_pow_q, best_pow_d;

  logic               clr, ld, en;
  logic [PHASE_W-1:0] phase_ld;
  logic signed [ACC_W-1:0] i_acc, q_acc;
  logic [63:0]        pow_full;
  logic [POW_W-1:0]   pow;

  psk_iq_integrator #(.PHASE_W(PHASE_W), .ACC_W(ACC_W)) u_iq (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .clear_i      (clr),
    .load_phase_i (ld),
    .en_i         (en),
    .sig_i        (sig_i),
    .phase_ld_i   (phase_ld),
    .fcw_i        (fcw_q),
    .i_acc_o      (i_acc),
    .q_acc_o      (q_acc)
  );

  assign pow_full = pow_of(longint'(i_acc), longint'(q_acc));
  assign pow      = pow_full[POW_W-1:0];

  always_comb begin
    state_d    = state_q;
    fcw_d      = fcw_q;
    pcw_d      = pcw_q;
    off_d      = off_q;
    hyp_d      = hyp_q;
    cnt_d      = cnt_q;
    hyp_stb_d  = 1'b0;
    hyp_idx_d  = hyp_idx_q;
    hyp_pow_d  = hyp_pow_q;
    best_idx_d = best_idx_q;
    best_pow_d = best_pow_q;
    clr        = 1'b0;
    ld         = 1'b0;
    en         = 1'b0;
    phase_ld   = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          fcw_d   = fcw_i;
          pcw_d   = pcw_step_i;
          off_d   = '0;
          hyp_d   = '0;
          cnt_d   = '0;
          clr     = 1'b1;
          ld      = 1'b1;
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (sample_en_i) begin
          en    = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DWELL_LEN - 1)) state_d = EVAL;
        end
      end
      EVAL: begin
        hyp_stb_d = 1'b1;
        hyp_idx_d = hyp_q;
        hyp_pow_d = pow;
        // Strict compare: on a tie the earlier hypothesis wins.
        if (hyp_q == '0 || pow > best_pow_q) begin
          best_idx_d = hyp_q;
          best_pow_d = pow;
        end
        if (hyp_q != IDX_W'(N_HYP - 1)) begin
          hyp_d    = hyp_q + 1'b1;
          off_d    = off_q + pcw_q;
          phase_ld = off_q + pcw_q;
          ld       = 1'b1;
          clr      = 1'b1;
          cnt_d    = '0;
          state_d  = DWELL;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      fcw_q      <= '0;
      pcw_q      <= '0;
      off_q      <= '0;
      hyp_q      <= '0;
      cnt_q      <= '0;
      hyp_stb_q  <= 1'b0;
      hyp_idx_q  <= '0;
      hyp_pow_q  <= '0;
      best_idx_q <= '0;
      best_pow_q <= '0;
    end else begin
      state_q    <= state_d;
      fcw_q      <= fcw_d;
      pcw_q      <= pcw_d;
      off_q      <= off_d;
      hyp_q      <= hyp_d;
      cnt_q      <= cnt_d;
      hyp_stb_q  <= hyp_stb_d;
      hyp_idx_q  <= hyp_idx_d;
      hyp_pow_q  <= hyp_pow_d;
      best_idx_q <= best_idx_d;
      best_pow_q <= best_pow_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign hyp_stb_o  = hyp_stb_q;
  assign hyp_idx_o  = hyp_idx_q;
  assign hyp_pow_o  = hyp_pow_q;
  assign best_idx_o = best_idx_q;
  assign best_pow_o = best_pow_q;

endmodule

// File: tb/tb_psk_acq_dispatcher.sv
// Scoreboard bench: driver pushes model results per hypothesis, negedge monitor pops and compares.
module tb_psk_acq_dispatcher;

  localparam int PW = 12;
  localparam int AW = 8;
  localparam int DL = 96;
  localparam int NH = 16;
  localparam int IW = $clog2(NH);
  localparam int OW = 2 * AW;

  logic          clk = 1'b0;
  logic          rst_n, sig, sample_en, start;
  logic [PW-1:0] fcw, pcw;
  logic          busy, hyp_stb, done;
  logic [IW-1:0] hyp_idx, best_idx;
  logic [OW-1:0] hyp_pow, best_pow;

  psk_acq_dispatcher #(.PHASE_W(PW), .ACC_W(AW), .DWELL_LEN(DL), .N_HYP(NH)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .sig_i       (sig),
    .sample_en_i (sample_en),
    .start_i     (start),
    .fcw_i       (fcw),
    .pcw_step_i  (pcw),
    .busy_o      (busy),
    .hyp_stb_o   (hyp_stb),
    .hyp_idx_o   (hyp_idx),
    .hyp_pow_o   (hyp_pow),
    .done_o      (done),
    .best_idx_o  (best_idx),
    .best_pow_o  (best_pow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int pow;
    int cyc;
  } exp_t;

  exp_t exp_hyp[$];
  exp_t exp_done[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   obs_pow [NH];
  int   obs_best_idx, obs_best_pow;
  exp_t m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: correlate the accepted samples of hypothesis h against ideal
  // square-wave I/Q codes whose phase starts at h*pcw and advances by fcw.
  function automatic int model_pow(input int h, input logic [PW-1:0] f,
                                   input logic [PW-1:0] p, input bit s [DL]);
    int off, ph, iacc, qacc;
    bit ci, cq;
    off  = (h * int'(p)) % 4096;
    iacc = 0;
    qacc = 0;
    for (int k = 0; k < DL; k++) begin
      ph   = (off + k * int'(f)) % 4096;
      ci   = (ph >= 2048);
      cq   = (((ph + 1024) % 4096) >= 2048);
      iacc += (s[k] == ci) ? 1 : -1;
      qacc += (s[k] == cq) ? 1 : -1;
    end
    return iacc * iacc + qacc * qacc;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (hyp_stb) begin
        if (exp_hyp.size() == 0) chk("hyp_stb_unexpected", 1, 0);
        else begin
          m = exp_hyp.pop_front();
          chk("hyp_idx", hyp_idx, m.idx);
          chk("hyp_pow", hyp_pow, m.pow);
          chk("hyp_stb_cycle", cyc, m.cyc);
          obs_pow[hyp_idx] = int'(hyp_pow);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          m = exp_done.pop_front();
          chk("best_idx", best_idx, m.idx);
          chk("best_pow", best_pow, m.pow);
          chk("done_cycle", cyc, m.cyc);
          chk("busy_at_done", busy, 1);
          obs_best_idx = int'(best_idx);
          obs_best_pow = int'(best_pow);
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_hyp_stb"}, hyp_stb, 0);
    chk({tag, "_hyp_idx"}, hyp_idx, 0);
    chk({tag, "_hyp_pow"}, hyp_pow, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_best_idx"}, best_idx, 0);
    chk({tag, "_best_pow"}, best_pow, 0);
  endtask

  // mode: 0 random sig, 1 all ones, 2 square wave from 0x500 stepping 0x100.
  // en_mode: 0 always, 1 toggle, 2 random. abort_hyp >= 0 pulses reset mid-dwell.
  task automatic run_search(input logic [PW-1:0] f, input logic [PW-1:0] p, input int mode,
                            input int en_mode, input bit busy_starts, input int abort_hyp);
    bit            smp [DL];
    int            hyp, cnt, s, bi, bp, pw;
    bit            tog;
    logic [PW-1:0] sq;
    exp_t          e;
    hyp = 0; cnt = 0; bi = 0; bp = 0; tog = 1'b1; sq = 12'h500;
    for (int i = 0; i < NH; i++) obs_pow[i] = -1;
    obs_best_idx = -1;
    obs_best_pow = -1;
    chk("idle_before_start", busy, 0);
    s = cyc;
    start = 1'b1; fcw = f; pcw = p;
    sig = 1'($urandom); sample_en = 1'($urandom);
    tick();
    start = 1'b0; fcw = PW'($urandom); pcw = PW'($urandom);
    while (hyp < NH) begin
      if (cnt == DL) begin
        pw = model_pow(hyp, f, p, smp);
        e.idx = hyp; e.pow = pw; e.cyc = cyc + 1;
        exp_hyp.push_back(e);
        if (hyp == 0 || pw > bp) begin
          bi = hyp;
          bp = pw;
        end
        if (hyp == NH - 1) begin
          e.idx = bi; e.pow = bp;
          e.cyc = (en_mode == 0) ? s + NH * (DL + 1) + 1 : cyc + 1;
          exp_done.push_back(e);
        end
        sig = 1'($urandom); sample_en = 1'($urandom);
        start = busy_starts && ($urandom_range(0, 3) == 0);
        tick();
        hyp++;
        cnt = 0;
      end else if (hyp == abort_hyp && cnt == DL / 2) begin
        rst_n = 1'b0; start = 1'b0;
        tick();
        check_zero("abort");
        rst_n = 1'b1;
        exp_hyp.delete();
        exp_done.delete();
        repeat (4) tick();
        return;
      end else begin
        case (en_mode)
          0:       sample_en = 1'b1;
          1:       sample_en = tog;
          default: sample_en = ($urandom_range(0, 3) != 0);
        endcase
        tog = ~tog;
        case (mode)
          1:       sig = 1'b1;
          2:       sig = sq[PW-1];
          default: sig = 1'($urandom);
        endcase
        start = busy_starts && ($urandom_range(0, 3) == 0);
        if (sample_en) begin
          smp[cnt] = sig;
          cnt++;
          sq = sq + 12'h100;
        end
        tick();
      end
    end
    start = busy_starts && ($urandom_range(0, 1) == 0);
    sig = 1'($urandom); sample_en = 1'($urandom);
    tick();
    start = 1'b0;
  endtask

  task automatic check_square(input string tag);
    chk({tag, "_p1"}, obs_pow[1], 9216);
    chk({tag, "_p5"}, obs_pow[5], 9216);
    chk({tag, "_p9"}, obs_pow[9], 9216);
    chk({tag, "_p13"}, obs_pow[13], 9216);
    chk({tag, "_p3"}, obs_pow[3], 4608);
    chk({tag, "_p2"}, obs_pow[2], 5760);
    chk({tag, "_best_idx"}, obs_best_idx, 1);
    chk({tag, "_best_pow"}, obs_best_pow, 9216);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sig = 1'b0; sample_en = 1'b0; fcw = '0; pcw = '0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_search(12'h000, 12'h100, 1, 0, 1'b0, -1);
    for (int i = 0; i < NH; i++) chk($sformatf("ones_pow%0d", i), obs_pow[i], 18432);
    chk("ones_best_idx", obs_best_idx, 0);
    chk("ones_best_pow", obs_best_pow, 18432);

    run_search(12'h100, 12'h100, 2, 0, 1'b0, -1);
    check_square("sq");
    run_search(12'h100, 12'h100, 2, 1, 1'b1, -1);
    check_square("sq_toggle");

    run_search(12'h100, 12'h100, 2, 2, 1'b0, 7);
    run_search(12'h100, 12'h100, 2, 0, 1'b0, -1);
    check_square("sq_after_rst");

    run_search(12'hFFF, 12'hF00, 0, 2, 1'b1, -1);
    repeat (3) run_search(PW'($urandom), PW'($urandom), 0, 2, 1'b1, -1);

    repeat (5) tick();
    chk("hyp_queue_drained", exp_hyp.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
